// File: rtl/uart_reg_bridge_if.sv
// Shared-bus handshake between the register bridge and the buffered UART FIFOs.
// The bridge is the master; the UART side answers as the slave.
interface uart_reg_bridge_if #(
   parameter int WIDTH         = 8,
   parameter int ADDRESS_WIDTH = 4
);
   logic                     rx_valid;
   logic                     tx_ready;
   logic [ADDRESS_WIDTH-1:0] active_address;
   logic                     read_enable;
   logic                     write_enable;
   logic [WIDTH-1:0]         bus_rdata;
   logic [WIDTH-1:0]         bus_wdata;

   modport master (
      input  rx_valid, tx_ready, bus_rdata,
      output active_address, read_enable, write_enable, bus_wdata
   );

   modport slave (
      output rx_valid, tx_ready, bus_rdata,
      input  active_address, read_enable, write_enable, bus_wdata
   );
endinterface

// File: rtl/uart_reg_bridge.sv
// Serial command-frame parser giving a host read/write access to a small register file.
// Optional checksum byte per frame when UART_REG_BRIDGE_CHECKSUM_EN is defined.
module uart_reg_bridge #(
   parameter int WIDTH          = 8,
   parameter int ADDRESS_WIDTH  = 4,
   parameter int RX_ADDRESS     = 0,
   parameter int TX_ADDRESS     = 1,
   parameter int REG_COUNT      = 16,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                       clock,
   input  logic                       resetn,
   uart_reg_bridge_if.master          bus,
   output logic [WIDTH*REG_COUNT-1:0] regs_out,
   output logic                       frame_error
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]            TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDRESS_WIDTH-1:0] RX_ADDR      = ADDRESS_WIDTH'(RX_ADDRESS);
   localparam logic [ADDRESS_WIDTH-1:0] TX_ADDR      = ADDRESS_WIDTH'(TX_ADDRESS);
   localparam logic [WIDTH-1:0]         HEADER       = 8'hA5;
   localparam logic [WIDTH-1:0]         ACK          = 8'h06;
   localparam logic [WIDTH-1:0]         NAK          = 8'h15;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      DATA,
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
      CHECK,
`endif
      EXEC,
      RESP
   } state_t;

`ifdef UART_REG_BRIDGE_CHECKSUM_EN
   localparam state_t AFTER_PAYLOAD = CHECK;
`else
   localparam state_t AFTER_PAYLOAD = EXEC;
`endif

   state_t                   state_q, state_d;
   logic                     fetch_pending_q, fetch_pending_d;
   logic                     is_write_q, is_write_d;
   logic [3:0]               index_q, index_d;
   logic [WIDTH-1:0]         data_q, data_d;
   logic [WIDTH-1:0]         resp_q, resp_d;
   logic [TW-1:0]            timeout_q, timeout_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic                     frame_error_q, frame_error_d;
   logic [WIDTH-1:0]         regs_q [REG_COUNT];
   logic [WIDTH-1:0]         regs_d [REG_COUNT];
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
   logic [WIDTH-1:0]         chk_acc_q, chk_acc_d;
   logic                     chk_ok_q, chk_ok_d;
`endif

   logic             read_enable;
   logic             write_enable;
   logic             in_frame;
   logic             capture;
   logic             timeout_hit;
   logic             bad_index;
   logic [WIDTH-1:0] read_value;

   always_comb begin
      state_d         = state_q;
      fetch_pending_d = fetch_pending_q;
      is_write_d      = is_write_q;
      index_d         = index_q;
      data_d          = data_q;
      resp_d          = resp_q;
      timeout_d       = '0;
      addr_d          = addr_q;
      frame_error_d   = 1'b0;
      regs_d          = regs_q;
      read_enable     = 1'b0;
      write_enable    = 1'b0;
      read_value      = '0;
      in_frame        = 1'b0;
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
      chk_acc_d       = chk_acc_q;
      chk_ok_d        = chk_ok_q;
`endif

      case (state_q)
         CMD, DATA: in_frame = 1'b1;
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
         CHECK:     in_frame = 1'b1;
`endif
         default:   in_frame = 1'b0;
      endcase

      // A pending fetch always completes before the timeout may fire, so a
      // popped byte is never stranded by a frame abort.
      capture     = fetch_pending_q;
      timeout_hit = in_frame && !capture && (timeout_q == TIMEOUT_LAST);
      bad_index   = {1'b0, index_q} >= 5'(REG_COUNT);

      if (in_frame && !capture && !timeout_hit) begin
         timeout_d = timeout_q + 1'b1;
      end

      if ((in_frame || state_q == IDLE) && !capture && !timeout_hit && bus.rx_valid && resetn) begin
         read_enable     = 1'b1;
         fetch_pending_d = 1'b1;
         addr_d          = RX_ADDR;
      end
      if (capture) begin
         fetch_pending_d = 1'b0;
      end

      for (int i = 0; i < REG_COUNT; i++) begin
         if (index_q == 4'(i)) begin
            read_value = regs_q[i];
         end
      end

      case (state_q)
         IDLE: begin
            if (capture && bus.bus_rdata == HEADER) begin
               state_d = CMD;
            end
         end
         CMD: begin
            if (capture) begin
               is_write_d = bus.bus_rdata[7];
               index_d    = bus.bus_rdata[3:0];
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
               chk_acc_d  = bus.bus_rdata;
`endif
               state_d    = bus.bus_rdata[7] ? DATA : AFTER_PAYLOAD;
            end
         end
         DATA: begin
            if (capture) begin
               data_d    = bus.bus_rdata;
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
               chk_acc_d = chk_acc_q ^ bus.bus_rdata;
`endif
               state_d   = AFTER_PAYLOAD;
            end
         end
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
         CHECK: begin
            if (capture) begin
               chk_ok_d = (bus.bus_rdata == chk_acc_q);
               state_d  = EXEC;
            end
         end
`endif
         EXEC: begin
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
            if (bad_index || !chk_ok_q) begin
`else
            if (bad_index) begin
`endif
               resp_d        = NAK;
               frame_error_d = 1'b1;
            end else if (is_write_q) begin
               for (int i = 0; i < REG_COUNT; i++) begin
                  if (index_q == 4'(i)) begin
                     regs_d[i] = data_q;
                  end
               end
               resp_d = ACK;
            end else begin
               resp_d = read_value;
            end
            state_d = RESP;
         end
         RESP: begin
            if (bus.tx_ready && resetn) begin
               write_enable = 1'b1;
               addr_d       = TX_ADDR;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (timeout_hit) begin
         state_d       = IDLE;
         frame_error_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q         <= IDLE;
         fetch_pending_q <= 1'b0;
         is_write_q      <= 1'b0;
         index_q         <= '0;
         data_q          <= '0;
         resp_q          <= '0;
         timeout_q       <= '0;
         addr_q          <= '0;
         frame_error_q   <= 1'b0;
         regs_q          <= '{default: '0};
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
         chk_acc_q       <= '0;
         chk_ok_q        <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         fetch_pending_q <= fetch_pending_d;
         is_write_q      <= is_write_d;
         index_q         <= index_d;
         data_q          <= data_d;
         resp_q          <= resp_d;
         timeout_q       <= timeout_d;
         addr_q          <= addr_d;
         frame_error_q   <= frame_error_d;
         regs_q          <= regs_d;
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
         chk_acc_q       <= chk_acc_d;
         chk_ok_q        <= chk_ok_d;
`endif
      end
   end

   // Address only carries meaning under a strobe; otherwise it parks on the last one used.
   assign bus.read_enable    = read_enable;
   assign bus.write_enable   = write_enable;
   assign bus.active_address = read_enable ? RX_ADDR : (write_enable ? TX_ADDR : addr_q);
   assign bus.bus_wdata      = write_enable ? resp_q : '0;
   assign frame_error        = frame_error_q;

   for (genvar g = 0; g < REG_COUNT; g++) begin : g_regs_out
      assign regs_out[g*WIDTH +: WIDTH] = regs_q[g];
   end

endmodule

// File: doc/uart_reg_bridge.md
# uart_reg_bridge

Register-access bridge downstream of the buffered UART on the shared address bus. Pops received bytes from the UART RX FIFO address, parses fixed-format command frames, and reads or writes a local register file. Pushes one response byte per frame to the UART TX FIFO address. Gives a host PC byte-level access to control registers over serial.

## Interface
- width, 8: byte/bus data width; must be 8.
- address_width, 4: bus address width.
- rx_address, 0: bus address popping the UART RX FIFO.
- tx_address, 1: bus address pushing the UART TX FIFO.
- reg_count, 16: register file depth, 1..16.
- timeout_cycles, 100000: max idle cycles between bytes of one frame.

- clock  in  1  system clock; everything on posedge.
- resetn  in  1  synchronous, active-low reset.
- rx_valid  in  1  UART RX FIFO not empty.
- tx_ready  in  1  UART TX FIFO not full.
- active_address  out  address_width  bus address for the current access.
- read_enable  out  1  one-cycle pop strobe.
- write_enable  out  1  one-cycle push strobe.
- bus_rdata  in  width  RX FIFO data; valid the cycle after read_enable.
- bus_wdata  out  width  TX byte; valid with write_enable.
- regs_out  out  width*reg_count  register file, reg i at bits [i*width +: width].
- frame_error  out  1  one-cycle pulse on dropped frame (timeout, bad index, bad checksum).

## Operation
- Frame: header 0xA5, cmd byte, optional data byte, optional checksum byte. cmd[7]=1 write, 0 read; cmd[6:4] ignored; cmd[3:0] register index.
- Write frame: 0xA5, cmd, data. Read frame: 0xA5, cmd.
- States: IDLE, CMD, DATA, CHECK, EXEC, RESP.
- Byte fetch, in IDLE/CMD/DATA/CHECK: when rx_valid=1 and no fetch pending, drive active_address=rx_address, read_enable=1 for one cycle. Capture bus_rdata on the next cycle. rx_valid is ignored during that wait cycle.
- IDLE: a non-0xA5 byte is discarded and the state stays IDLE. 0xA5 goes to CMD.
- CMD: a write goes to DATA. A read goes to EXEC, or to CHECK when the macro is defined.
- DATA: goes to EXEC, or to CHECK when the macro is defined.
- EXEC (one cycle):
  - Index >= reg_count: response 0x15, frame_error pulse, no register change.
  - Write: reg[index] <= data; response 0x06.
  - Read: response is reg[index].
  - Always goes to RESP.
- RESP: wait for tx_ready=1. Then drive active_address=tx_address, write_enable=1, bus_wdata=response for one cycle, and go to IDLE.
- Timeout: counter clears on every captured byte and counts in CMD/DATA/CHECK. On reaching timeout_cycles-1: go to IDLE, pulse frame_error, send no response.
- read_enable and write_enable are never high in the same cycle.

## Timing
- Reset: state=IDLE; read_enable=0, write_enable=0, active_address=0, bus_wdata=0; all registers 0; frame_error=0; timeout counter 0.
- Reset mid-frame aborts the frame with no response. A pending fetch is dropped, so the popped byte is lost.
- Per byte, rx_valid steady: 2 cycles (strobe, capture).
- Capture of last frame byte to write_enable, tx_ready high: 2 cycles (EXEC, RESP).
- regs_out updates the cycle after EXEC.
- Between strobes active_address holds its last value; it is only meaningful while a strobe is high.

## Configuration
- UART_REG_BRIDGE_CHECKSUM_EN defined:
  - CHECK state is present; every frame ends with a checksum byte.
  - Checksum = cmd XOR data for writes, cmd for reads.
  - On mismatch: no register change, response 0x15, frame_error pulse.
- Macro not defined: no CHECK state; frames carry no checksum byte.

## Test plan
- Write then read, macro undefined: RX bytes A5 83 5C -> TX 06, regs_out reg3=0x5C. Then A5 03 -> TX 5C.
- Garbage resync: RX 00 FF A5 81 11 -> TX 06 only, reg1=0x11. Leading bytes are discarded with no frame_error.
- Bad index, reg_count=8: RX A5 8A 77 -> TX 15, frame_error pulses once, regs_out unchanged.
- Timeout, timeout_cycles=50: RX A5 82 then 60 idle cycles -> no TX, frame_error pulse, reg2=0. Next A5 02 -> TX 00.
- Backpressure: hold tx_ready=0 for 20 cycles after A5 84 01 -> no write_enable until tx_ready rises; exactly one 06 pushed, no RX pops meanwhile.
- Macro defined: A5 85 AA 2F -> TX 06, reg5=0xAA. A5 85 AA 00 -> TX 15, frame_error pulse, reg5 unchanged.
